imem_loader: RTL and testbench

- Boot-time program loader and port arbiter for the single-port 16-bit instruction memory.
- Receives a length-prefixed byte stream over a valid/ready handshake, assembles 16-bit words and writes them into instruction memory.
- Holds the CPU stalled while loading, then hands the memory address port back to the fetch PC and releases the CPU.
- Sits between the byte source (UART/debug receiver), the instruction memory and the CPU core.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_byte_assembler.sv | 28 ++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, FSM state encoding and state-decode helpers for the instruction-memory loader
package imem_loader_pkg;
  localparam int COL         = 16;
  localparam int BITS_SIZE_I = 8;
  localparam int ROW_I       = 1 << BITS_SIZE_I;
  localparam int BYTE_W      = 8;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_DAT_HI = 4'd3,
    S_DAT_LO = 4'd4,
    S_WR     = 4'd5,
    S_RUN    = 4'd6,
    S_ERR    = 4'd7,
    S_CK_HI  = 4'd8,
    S_CK_LO  = 4'd9
  } state_t;
  function automatic logic rx_state(input state_t s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CK_HI, S_CK_LO};
  endfunction
  function automatic logic hi_state(input state_t s);
    return s inside {S_LEN_HI, S_DAT_HI, S_CK_HI};
  endfunction
  function automatic logic busy_state(input state_t s);
    return rx_state(s) || s == S_WR;
  endfunction
endpackage

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler: pairs a high and low stream byte into a 16-bit word with a one-cycle word_valid pulse
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [BYTE_W-1:0] rx_byte,
  output logic [COL-1:0]    word,
  output logic [COL-1:0]    peek,
  output logic              word_valid
);
  logic [BYTE_W-1:0] hi_q;
  // peek lets the FSM judge a length/checksum field in the same cycle its low byte arrives
  assign peek = {hi_q, rx_byte};
  // latch the high byte, then the full word when its low byte transfers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_q       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      if (hi_en) hi_q <= rx_byte;
      if (lo_en) word <= {hi_q, rx_byte};
      word_valid <= lo_en;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader and address-port arbiter for the 16-bit instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing 16-bit checksum check
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = BITS_SIZE_I,
  parameter int DATA_W = COL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [COL-1:0]    cpu_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_DONE = S_CK_HI;
`else
  localparam state_t S_DONE = S_RUN;
`endif
  state_t          state, nx;
  logic [15:0]     n;
  logic [ADDR_W:0] cnt;
  logic [16:0]     cnt_nx;
  logic [COL-1:0]  word, peek;
  logic            word_valid, xfer, last, unused_pc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0]     sum;
`endif
  imem_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .hi_en      (xfer && hi_state(state)),
    .lo_en      (xfer && state == S_DAT_LO),
    .rx_byte    (rx_data),
    .word       (word),
    .peek       (peek),
    .word_valid (word_valid)
  );
  assign rx_ready  = rx_state(state);
  assign busy      = busy_state(state);
  assign cpu_run   = state == S_RUN;
  assign err       = state == S_ERR;
  assign mem_we    = state == S_WR;
  assign mem_wdata = word;
  assign mem_addr  = cpu_run ? cpu_pc[ADDR_W-1:0] : cnt[ADDR_W-1:0];
  assign xfer      = rx_valid && rx_ready;
  assign cnt_nx    = 17'(cnt) + 17'd1;
  assign last      = cnt_nx == {1'b0, n};
  assign unused_pc = &{1'b0, cpu_pc};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nx;
  // next state: restart only from IDLE/RUN/ERR, byte states advance on a transfer
  always_comb begin
    nx = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: nx = start ? S_LEN_HI : state;
      S_LEN_HI: nx = xfer ? S_LEN_LO : state;
      S_LEN_LO: nx = !xfer ? state : peek == '0 ? S_DONE : {1'b0, peek} > DEPTH ? S_ERR : S_DAT_HI;
      S_DAT_HI: nx = xfer ? S_DAT_LO : state;
      S_DAT_LO: nx = xfer ? S_WR : state;
      S_WR:     nx = last ? S_DONE : S_DAT_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CK_HI:  nx = xfer ? S_CK_LO : state;
      S_CK_LO:  nx = !xfer ? state : peek == sum ? S_RUN : S_ERR;
`endif
      default:  nx = S_IDLE;
    endcase
  end
  // word count capture and write-address counter, stepped by each assembled word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n   <= '0;
      cnt <= '0;
    end else begin
      if (start && !busy) cnt <= '0;
      if (xfer && state == S_LEN_LO) begin
        n   <= peek;
        cnt <= '0;
      end
      if (word_valid) cnt <= cnt + 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  // running mod-2^16 sum of every word written during this load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (xfer && state == S_LEN_LO) sum <= '0;
    else if (word_valid) sum <= sum + word;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a queue-based stream/write model
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK_EXTRA = 2;
`else
  localparam int CK_EXTRA = 0;
`endif
  logic        clk = 0, rst_n = 0, start = 0, rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic [15:0] cpu_pc = 0;
  logic        rx_ready, mem_we, cpu_run, busy, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  int n_chk = 0, n_fail = 0;
  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cpu_pc(cpu_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_run(cpu_run), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  // record every memory write seen mid-cycle
  always @(negedge clk) if (rst_n && mem_we) begin
    wa.push_back(mem_addr);
    wd.push_back(mem_wdata);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // mode 0: valid always high, 1: valid every other cycle, 2: random valid
  task automatic run_load(input logic [15:0] words[$], input logic [15:0] len, input int mode,
                          input bit bad_ck, input int start_at);
    logic [7:0]  b[$];
    logic [15:0] sum, ck;
    int idx, cyc, n_exp, used_exp, cyc_exp;
    bit fits, exp_err;
    sum = 0; idx = 0; cyc = 0;
    fits = len <= 16'd256;
    b.push_back(len[15:8]);
    b.push_back(len[7:0]);
    if (fits) foreach (words[i]) begin
      b.push_back(words[i][15:8]);
      b.push_back(words[i][7:0]);
      sum += words[i];
    end
    exp_err = !fits;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (fits) begin
      ck = bad_ck ? sum + 16'd1 : sum;
      b.push_back(ck[15:8]);
      b.push_back(ck[7:0]);
      exp_err = bad_ck;
    end
`else
    ck = sum;
`endif
    n_exp    = fits ? int'(len) : 0;
    used_exp = fits ? b.size() : 2;
    cyc_exp  = fits ? 2 + 3 * int'(len) + CK_EXTRA : 2;
    wa.delete();
    wd.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    while (!cpu_run && !err && cyc < 4000) begin
      start = cyc == start_at;
      if (idx < b.size() && (mode == 0 || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(1, 0) == 1))) begin
        rx_valid = 1;
        rx_data  = b[idx];
        if (rx_ready) idx++;
      end else begin
        rx_valid = 0;
        rx_data  = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    check("finished", cyc < 4000, 1);
    check("err", err, exp_err);
    check("cpu_run", cpu_run, !exp_err);
    check("busy_end", busy, 0);
    check("bytes_used", idx, used_exp);
    if (mode == 0) check("load_cycles", cyc, cyc_exp);
    check("n_writes", wa.size(), n_exp);
    for (int i = 0; i < n_exp && i < wa.size(); i++) begin
      check("waddr", wa[i], i[7:0]);
      check("wdata", wd[i], words[i]);
    end
    rx_valid = 1;
    rx_data  = 8'hA5;
    cpu_pc   = 16'($urandom);
    #1;
    check("rx_ready_after", rx_ready, 0);
    if (!exp_err) check("pc_mux", mem_addr, cpu_pc[7:0]);
    @(negedge clk);
    check("no_write_after", mem_we, 0);
    rx_valid = 0;
    if (ck == 16'hFFFF) check("ck_unused", 0, 0);
  endtask
  initial begin
    logic [15:0] q[$], e[$];
    #12;
    check("rst_cpu_run", cpu_run, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1;
    rx_valid = 1;
    rx_data  = 8'h03;
    repeat (3) @(negedge clk);
    check("idle_rx_ready", rx_ready, 0);
    check("idle_busy", busy, 0);
    check("idle_cpu_run", cpu_run, 0);
    rx_valid = 0;
    q.push_back(16'h1234);
    q.push_back(16'hABCD);
    q.push_back(16'h0001);
    run_load(q, 16'd3, 0, 0, -1);
    cpu_pc = 16'h0102;
    #1;
    check("pc_0102", mem_addr, 8'h02);
    run_load(q, 16'd3, 1, 0, -1);
    run_load(e, 16'h0101, 0, 0, -1);
    e.push_back(16'hBEEF);
    run_load(e, 16'd1, 0, 0, -1);
    run_load(q, 16'd3, 0, 0, 4);
    e.delete();
    run_load(e, 16'd0, 0, 0, -1);
    e.push_back(16'h1234);
    e.push_back(16'h0001);
    run_load(e, 16'd2, 0, 0, -1);
    run_load(e, 16'd2, 0, 1, -1);
    e.delete();
    for (int i = 0; i < 256; i++) e.push_back(16'($urandom));
    run_load(e, 16'd256, 0, 0, -1);
    for (int t = 0; t < 20; t++) begin
      int len;
      e.delete();
      len = $urandom_range(12, 0);
      for (int i = 0; i < len; i++) e.push_back(16'($urandom));
      if ($urandom_range(7, 0) == 0) run_load(e, 16'($urandom_range(65535, 257)), $urandom_range(2, 0), 0, -1);
      else run_load(e, 16'(len), $urandom_range(2, 0), $urandom_range(1, 0) == 1, -1);
    end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    rx_valid = 1;
    e.delete();
    e.push_back(16'h0005);
    e.push_back(16'h1234);
    for (int i = 0; i < 4; i++) begin
      rx_data = i % 2 == 0 ? e[i / 2][15:8] : e[i / 2][7:0];
      @(negedge clk);
    end
    rx_valid = 0;
    check("busy_pre_reset", busy, 1);
    check("we_pre_reset", mem_we, 1);
    rst_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cpu_run", cpu_run, 0);
    check("mid_rst_rx_ready", rx_ready, 0);
    check("mid_rst_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_cpu_run", cpu_run, 0);
    run_load(q, 16'd3, 2, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
